// File: rtl/rf_write_sched.sv
// Purpose: shares the register file's single write port between the WB stage and a
//          buffered long-latency (mult/div) result stream, and tracks pending registers.
// Latency: WB write 0 cycles (combinational); buffered result 1..1+STARVE_MAX cycles.
// Backpressure: mc_ready drops when the buffer is full; wb_hold stalls WB after
//               STARVE_MAX consecutive denied cycles for a non-empty buffer.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data         WB stage write request
//   mc_issue/mc_issue_addr        long-latency op issue (marks destination pending)
//   mc_valid/mc_ready/mc_addr/mc_data  long-latency result handshake
//   id_rs/id_rt/id_rd, stall      decode hazard query
//   wb_hold                       WB must re-present its write next cycle
//   rf_regwrite/rf_writeReg/rf_writeData  register file write port
//   sb_err                        sticky protocol-error flag
module rf_write_sched #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_addr,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    output logic        stall,
    output logic        wb_hold,
    output logic        rf_regwrite,
    output logic [4:0]  rf_writeReg,
    output logic [31:0] rf_writeData,
    output logic        sb_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [4:0]       buf_addr [DEPTH];
    logic [31:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fill;
    logic [STV_W-1:0] starve;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        wb_sel;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        issue_err;
    logic        push_err;
    logic        full_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (fill == '0);
    assign full      = (fill == CNT_W'(DEPTH));
    assign head_addr = buf_addr[rd_ptr];
    assign head_data = buf_data[rd_ptr];

    // A full buffer refuses a result even if it pops in the same cycle.
    assign mc_ready = !full && !rst;
    assign push     = mc_valid && mc_ready;
    assign wb_hold  = !rst && (starve == STV_W'(STARVE_MAX));

    // Write-port arbitration. A WB write to r0 never claims the port.
    always_comb begin
        pop    = 1'b0;
        wb_sel = 1'b0;
        if (!rst) begin
            if (wb_hold && !empty) begin
                pop = 1'b1;
            end else if (wb_we && (wb_addr != 5'd0)) begin
                wb_sel = 1'b1;
            end else if (!empty) begin
                pop = 1'b1;
            end
        end
    end

    assign rf_regwrite  = pop || wb_sel;
    assign rf_writeReg  = (wb_sel || empty) ? wb_addr : head_addr;
    assign rf_writeData = (wb_sel || empty) ? wb_data : head_data;

    // Clear on pop first, then set on issue, so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head_addr] = 1'b0;
        end
        if (mc_issue) begin
            pending_nxt[mc_issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Re-issuing a register whose result is being committed this very cycle is legal.
    assign issue_err = mc_issue && (mc_issue_addr != 5'd0) && pending[mc_issue_addr]
                       && !(pop && (head_addr == mc_issue_addr));
    assign push_err  = push && !pending[mc_addr];
    assign full_err  = mc_valid && full;

    // Registered pending vector: stall stays up through the pop cycle.
    assign stall = !rst && (pending[id_rs] || pending[id_rt] || pending[id_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            starve  <= '0;
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (empty || pop) begin
                starve <= '0;
            end else begin
                starve <= starve + 1'b1;
            end
            pending <= pending_nxt;
            if (issue_err || push_err || full_err) begin
                sb_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by fill.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= mc_addr;
            buf_data[wr_ptr] <= mc_data;
        end
    end

endmodule

// File: tb/tb_rf_write_sched.sv
// Purpose: directed self-checking bench for rf_write_sched (DEPTH=2, STARVE_MAX=4).
// Latency: inputs driven 1 time unit after posedge, outputs checked 1 unit later.
// Backpressure: exercises full buffer, starvation hold and reset with pending state.
module tb_rf_write_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        stall;
    logic        wb_hold;
    logic        rf_regwrite;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_sched #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .mc_issue     (mc_issue),
        .mc_issue_addr(mc_issue_addr),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_addr      (mc_addr),
        .mc_data      (mc_data),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .stall        (stall),
        .wb_hold      (wb_hold),
        .rf_regwrite  (rf_regwrite),
        .rf_writeReg  (rf_write_reg),
        .rf_writeData (rf_write_data),
        .sb_err       (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mc_issue = 1'b0; mc_issue_addr = 5'd0;
        mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 32'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    endtask

    task automatic issue(input logic [4:0] a);
        mc_issue = 1'b1; mc_issue_addr = a;
        tick();
        mc_issue = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        // Reset state, rst still high
        settle();
        chk("rst_mc_ready", mc_ready, 0);
        chk("rst_regwrite", rf_regwrite, 0);
        chk("rst_wb_hold", wb_hold, 0);
        chk("rst_stall", stall, 0);
        chk("rst_sb_err", sb_err, 0);
        rst = 1'b0;
        tick();

        // 1: issue r8, decode stalls, result committed, stall drops next cycle
        issue(5'd8);
        id_rs = 5'd8;
        settle();
        chk("t1_stall_pending", stall, 1);
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'h0000_002A;
        settle();
        chk("t1_ready", mc_ready, 1);
        chk("t1_no_bypass", rf_regwrite, 0);
        tick();
        mc_valid = 1'b0;
        settle();
        chk("t1_pop_we", rf_regwrite, 1);
        chk("t1_pop_reg", rf_write_reg, 8);
        chk("t1_pop_data", rf_write_data, 32'h2A);
        chk("t1_stall_in_pop", stall, 1);
        tick();
        chk("t1_stall_drop", stall, 0);
        chk("t1_idle_we", rf_regwrite, 0);
        id_rs = 5'd0;

        // 2: WB owns the port over a fresh push; WB to r0 does not block
        issue(5'd9);
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h55;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        settle();
        chk("t2_wb_we", rf_regwrite, 1);
        chk("t2_wb_reg", rf_write_reg, 3);
        chk("t2_wb_data", rf_write_data, 32'h11);
        tick();
        mc_valid = 1'b0;
        wb_addr = 5'd0; wb_data = 32'h77;
        settle();
        chk("t2_r0_pop_we", rf_regwrite, 1);
        chk("t2_r0_pop_reg", rf_write_reg, 9);
        chk("t2_r0_pop_data", rf_write_data, 32'h55);
        tick();
        wb_we = 1'b0;
        settle();
        chk("t2_idle_we", rf_regwrite, 0);
        chk("t2_sb_err", sb_err, 0);

        // 3: starvation - 4 denied cycles, then one held WB cycle pops the entry
        issue(5'd10);
        id_rd = 5'd10;
        mc_valid = 1'b1; mc_addr = 5'd10; mc_data = 32'h0000_A0A0;
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        settle();
        chk("t3_push_wb_reg", rf_write_reg, 4);
        tick();
        mc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_addr = 5'(5 + i);
            settle();
            chk("t3_denied_hold", wb_hold, 0);
            chk("t3_denied_reg", rf_write_reg, 32'(5 + i));
            tick();
        end
        wb_addr = 5'd20;
        settle();
        chk("t3_hold", wb_hold, 1);
        chk("t3_hold_we", rf_regwrite, 1);
        chk("t3_hold_reg", rf_write_reg, 10);
        chk("t3_hold_data", rf_write_data, 32'hA0A0);
        chk("t3_hold_stall", stall, 1);
        tick();
        chk("t3_release", wb_hold, 0);
        chk("t3_wb_again_reg", rf_write_reg, 20);
        chk("t3_stall_clear", stall, 0);
        id_rd = 5'd0;

        // 4: fill DEPTH=2 under busy WB, then mc_valid while full
        issue(5'd11);
        issue(5'd12);
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
        mc_valid = 1'b1; mc_addr = 5'd11; mc_data = 32'h1;
        settle();
        chk("t4_ready_0", mc_ready, 1);
        tick();
        mc_addr = 5'd12; mc_data = 32'h2;
        settle();
        chk("t4_ready_1", mc_ready, 1);
        tick();
        mc_valid = 1'b0;
        settle();
        chk("t4_full_ready", mc_ready, 0);
        chk("t4_pre_err", sb_err, 0);
        mc_valid = 1'b1; mc_addr = 5'd11; mc_data = 32'hDEAD;
        tick();
        mc_valid = 1'b0;
        wb_we = 1'b0;
        settle();
        chk("t4_full_err", sb_err, 1);
        chk("t4_head0_reg", rf_write_reg, 11);
        chk("t4_head0_data", rf_write_data, 32'h1);
        tick();
        chk("t4_head1_reg", rf_write_reg, 12);
        chk("t4_head1_data", rf_write_data, 32'h2);
        tick();
        chk("t4_drained", rf_regwrite, 0);
        chk("t4_err_sticky", sb_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_err_cleared", sb_err, 0);

        // 5: issue to r5 while the buffered r5 pops - set wins, no error; re-issue errors
        issue(5'd5);
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'h5;
        tick();
        mc_valid = 1'b0;
        mc_issue = 1'b1; mc_issue_addr = 5'd5;
        settle();
        chk("t5_pop_reg", rf_write_reg, 5);
        tick();
        mc_issue = 1'b0;
        id_rs = 5'd5;
        settle();
        chk("t5_still_pending", stall, 1);
        chk("t5_no_err", sb_err, 0);
        chk("t5_empty", rf_regwrite, 0);
        issue(5'd5);
        chk("t5_reissue_err", sb_err, 1);

        // 6: reset with two buffered entries and pending bits
        issue(5'd6);
        issue(5'd7);
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h2;
        mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'h6;
        tick();
        mc_addr = 5'd7; mc_data = 32'h7;
        tick();
        mc_valid = 1'b0;
        id_rs = 5'd6; id_rt = 5'd7; id_rd = 5'd5;
        settle();
        chk("t6_full", mc_ready, 0);
        chk("t6_stall_before", stall, 1);
        rst = 1'b1;
        settle();
        chk("t6_rst_ready", mc_ready, 0);
        chk("t6_rst_we", rf_regwrite, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_hold", wb_hold, 0);
        tick();
        rst = 1'b0;
        wb_we = 1'b0;
        settle();
        chk("t6_post_we", rf_regwrite, 0);
        chk("t6_post_stall", stall, 0);
        chk("t6_post_err", sb_err, 0);
        chk("t6_post_ready", mc_ready, 1);
        tick();
        chk("t6_still_empty", rf_regwrite, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
